rpsc_ff_annunciator: RTL and testbench

RPSC_FF_ANNUNCIATOR -- requirements
Module: rpsc_ff_annunciator

---
 rtl/rpsc_ff_annunciator.sv | 123 ++++++++++++
 tb/tb_rpsc_ff_annunciator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_ff_annunciator.sv
// rtl/rpsc_ff_annunciator.sv - first-fault annunciator with debounce, lock-in, ack, flash and first-out capture
module rpsc_ff_annunciator #(
  parameter int              N_CH         = 8,
  parameter int              DEBOUNCE_CYC = 4,
  parameter int              FLASH_DIV    = 16,
  parameter logic [N_CH-1:0] ILK_MASK     = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_ff_in,
  input  logic            i_ack,
  input  logic            i_lamp_test,
  output logic [N_CH-1:0] o_ff_out,
  output logic [N_CH-1:0] o_ff_la,
  output logic [N_CH-1:0] o_first_out,
  output logic            o_emergency,
  output logic            o_interlock
);

  typedef enum logic [1:0] {
    ST_NORM = 2'd0,
    ST_ALM  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          state     [N_CH];
  state_t          state_nxt [N_CH];
  logic [7:0]      db_cnt    [N_CH];
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] filt;
  logic [15:0]     flash_cnt;
  logic            flash_phase;
  logic            ack_q;

  logic            ack_ev;
  logic            flash_wrap;
  logic            phase_nxt;
  logic            all_norm;
  logic [N_CH-1:0] enter;
  logic [N_CH-1:0] enter_low;
  logic [N_CH-1:0] first_base;
  logic [N_CH-1:0] first_nxt;
  logic [N_CH-1:0] ff_nxt;
  logic [N_CH-1:0] la_nxt;

  always_comb begin
    ack_ev     = i_ack & ~ack_q;
    flash_wrap = (flash_cnt == 16'(FLASH_DIV - 1));
    phase_nxt  = flash_wrap ? ~flash_phase : flash_phase;
    all_norm   = 1'b1;
    enter      = '0;
    ff_nxt     = '0;
    la_nxt     = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        ST_NORM: if (filt[i]) state_nxt[i] = ST_ALM;
        ST_ALM:  if (ack_ev) state_nxt[i] = filt[i] ? ST_ACK : ST_NORM;
        ST_ACK:  if (!filt[i]) state_nxt[i] = ST_NORM;
        default: state_nxt[i] = ST_NORM;
      endcase
      if (state[i] != ST_NORM) all_norm = 1'b0;
      enter[i]  = (state[i] == ST_NORM) && (state_nxt[i] == ST_ALM);
      ff_nxt[i] = (state_nxt[i] != ST_NORM);
      la_nxt[i] = ((state_nxt[i] == ST_ALM) && phase_nxt) || (state_nxt[i] == ST_ACK);
    end
    // Lowest-index new alarm wins when several arrive on the same edge.
    enter_low = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (enter[i]) enter_low = '0;
      if (enter[i]) enter_low[i] = 1'b1;
    end
    first_base = all_norm ? '0 : o_first_out;
    first_nxt  = (first_base == '0) ? enter_low : first_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      filt        <= '0;
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
      ack_q       <= 1'b0;
      o_ff_out    <= '0;
      o_ff_la     <= '0;
      o_first_out <= '0;
      o_emergency <= 1'b0;
      o_interlock <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state[i]  <= ST_NORM;
        db_cnt[i] <= '0;
      end
    end else begin
      sync1       <= i_ff_in;
      sync2       <= sync1;
      ack_q       <= i_ack;
      flash_cnt   <= flash_wrap ? 16'd0 : flash_cnt + 16'd1;
      flash_phase <= phase_nxt;
      for (int i = 0; i < N_CH; i++) begin
        // Count consecutive disagreeing samples; any agreement restarts the window.
        if (sync2[i] != filt[i]) begin
          if (db_cnt[i] == 8'(DEBOUNCE_CYC - 1)) begin
            filt[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
        state[i] <= state_nxt[i];
      end
      o_ff_out    <= ff_nxt;
      o_ff_la     <= i_lamp_test ? '1 : la_nxt;
      o_first_out <= first_nxt;
      o_emergency <= |o_ff_out;
      o_interlock <= |(o_ff_out & ILK_MASK);
    end
  end

endmodule

// File: tb/tb_rpsc_ff_annunciator.sv
// tb/tb_rpsc_ff_annunciator.sv - directed and randomized bench with a behavioural annunciator model
module tb_rpsc_ff_annunciator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ff_in = '0;
  logic       ack = 1'b0;
  logic       lamp_test = 1'b1;
  logic [7:0] ff_out, ff_la, first_out;
  logic       emergency, interlock;

  logic [2:0] ff_in3 = '0;
  logic [2:0] ff_out3, ff_la3, first_out3;
  logic       emergency3, interlock3;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rpsc_ff_annunciator u_dut (
    .clk(clk), .reset(reset), .i_ff_in(ff_in), .i_ack(ack), .i_lamp_test(lamp_test),
    .o_ff_out(ff_out), .o_ff_la(ff_la), .o_first_out(first_out),
    .o_emergency(emergency), .o_interlock(interlock)
  );

  rpsc_ff_annunciator #(.N_CH(3), .ILK_MASK(3'b001)) u_dut3 (
    .clk(clk), .reset(reset), .i_ff_in(ff_in3), .i_ack(1'b0), .i_lamp_test(1'b0),
    .o_ff_out(ff_out3), .o_ff_la(ff_la3), .o_first_out(first_out3),
    .o_emergency(emergency3), .o_interlock(interlock3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: channel state 0=normal, 1=alarm, 2=acknowledged.
  int         m_st [8];
  int         m_s1 [8];
  int         m_s2 [8];
  int         m_filt [8];
  int         m_run [8];
  logic [7:0] m_ff, m_la, m_first;
  logic       m_em, m_il;
  logic       m_ackq;
  int         k;

  always @(posedge clk) begin
    logic       ack_ev;
    logic       all_norm;
    logic [7:0] entered;
    logic [7:0] old_ff;
    int         phase;
    int         ns;
    if (reset) begin
      for (int c = 0; c < 8; c++) begin
        m_st[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_filt[c] = 0; m_run[c] = 0;
      end
      m_ff = '0; m_la = '0; m_first = '0; m_em = 1'b0; m_il = 1'b0; m_ackq = 1'b0; k = 0;
    end else begin
      ack_ev = ack && !m_ackq;
      m_ackq = ack;
      k++;
      phase = (k / 16) % 2;
      old_ff = m_ff;
      all_norm = 1'b1;
      entered = '0;
      for (int c = 0; c < 8; c++) begin
        if (m_st[c] != 0) all_norm = 1'b0;
        ns = m_st[c];
        if (m_st[c] == 0 && m_filt[c] == 1) ns = 1;
        else if (m_st[c] == 1 && ack_ev) ns = (m_filt[c] == 1) ? 2 : 0;
        else if (m_st[c] == 2 && m_filt[c] == 0) ns = 0;
        if (m_st[c] == 0 && ns == 1) entered[c] = 1'b1;
        m_st[c] = ns;
        if (m_s2[c] != m_filt[c]) begin
          m_run[c]++;
          if (m_run[c] == 4) begin
            m_filt[c] = m_s2[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = int'(ff_in[c]);
        m_ff[c] = (m_st[c] != 0);
        m_la[c] = lamp_test || (m_st[c] == 2) || (m_st[c] == 1 && phase == 1);
      end
      if (all_norm) m_first = '0;
      if (m_first == 0 && entered != 0) begin
        for (int c = 7; c >= 0; c--) if (entered[c]) m_first = 8'(1 << c);
      end
      m_em = |old_ff;
      m_il = |old_ff;
    end
    #2;
    chk("ff_out", 32'(ff_out), 32'(m_ff));
    chk("ff_la", 32'(ff_la), 32'(m_la));
    chk("first_out", 32'(first_out), 32'(m_first));
    chk("emergency", 32'(emergency), 32'(m_em));
    chk("interlock", 32'(interlock), 32'(m_il));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ff_in = '0; ack = 1'b0; lamp_test = 1'b0;
    edges(1);
    chk("reset_ff_out", 32'(ff_out), 32'h0);
    chk("reset_first", 32'(first_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t_chg [2];
    int n_chg;
    logic prev;

    edges(2);
    chk("reset_la_lamp_ignored", 32'(ff_la), 32'h0);
    chk("reset_emergency", 32'(emergency), 32'h0);
    @(negedge clk);
    reset = 1'b0; lamp_test = 1'b0;

    // First fault on ch 2: exact latency, first-out, summaries, flash period.
    @(negedge clk); ff_in = 8'h04;
    edges(6);
    chk("lat_before", 32'(ff_out), 32'h0);
    edges(1);
    chk("lat_ff_out", 32'(ff_out), 32'h04);
    chk("lat_first", 32'(first_out), 32'h04);
    chk("lat_emerg_not_yet", 32'(emergency), 32'h0);
    edges(1);
    chk("lat_emerg", 32'(emergency), 32'h1);
    chk("lat_ilk", 32'(interlock), 32'h1);
    n_chg = 0; prev = ff_la[2];
    for (int i = 0; i < 60 && n_chg < 2; i++) begin
      edges(1);
      if (ff_la[2] != prev) begin t_chg[n_chg] = i; n_chg++; end
      prev = ff_la[2];
    end
    chk("flash_seen", 32'(n_chg), 32'd2);
    if (n_chg == 2) chk("flash_period", 32'(t_chg[1] - t_chg[0]), 32'd16);

    // Glitch rejection and lock-in on ch 5.
    do_reset();
    @(negedge clk); ff_in = 8'h20;
    edges(3);
    @(negedge clk); ff_in = 8'h00;
    edges(20);
    chk("glitch3", 32'(ff_out), 32'h0);
    @(negedge clk); ff_in = 8'h20;
    edges(4);
    @(negedge clk); ff_in = 8'h00;
    edges(20);
    chk("lockin", 32'(ff_out), 32'h20);

    // Simultaneous faults and later fault do not move first-out.
    do_reset();
    @(negedge clk); ff_in = 8'h42;
    edges(8);
    chk("simul_first", 32'(first_out), 32'h02);
    chk("simul_ff", 32'(ff_out), 32'h42);
    @(negedge clk); ff_in = 8'h43;
    edges(10);
    chk("later_first", 32'(first_out), 32'h02);
    chk("later_ff", 32'(ff_out), 32'h43);

    // Ack with ch 1 still high, ch 0/6 low; then ch 1 clears.
    @(negedge clk); ff_in = 8'h02;
    edges(12);
    @(negedge clk); ack = 1'b1;
    edges(1);
    chk("ack_ff", 32'(ff_out), 32'h02);
    chk("ack_lamp", 32'(ff_la[1]), 32'h1);
    @(negedge clk); ack = 1'b0; ff_in = 8'h00;
    edges(6);
    chk("clr_before", 32'(ff_out), 32'h02);
    edges(1);
    chk("clr_ff", 32'(ff_out), 32'h00);
    chk("clr_first_held", 32'(first_out), 32'h02);
    edges(1);
    chk("clr_first", 32'(first_out), 32'h00);

    // Ack on the entry edge leaves ch 3 flashing; lamp test leaves state alone.
    do_reset();
    @(negedge clk); ff_in = 8'h08;
    edges(6);
    @(negedge clk); ack = 1'b1;
    edges(1);
    chk("entry_ack_ff", 32'(ff_out), 32'h08);
    @(negedge clk); ack = 1'b0;
    n_chg = 0; prev = ff_la[3];
    for (int i = 0; i < 40 && n_chg < 1; i++) begin
      edges(1);
      if (ff_la[3] != prev) n_chg++;
      prev = ff_la[3];
    end
    chk("entry_ack_flash", 32'(n_chg), 32'd1);
    @(negedge clk); lamp_test = 1'b1;
    edges(1);
    chk("lamp_la", 32'(ff_la), 32'hff);
    chk("lamp_ff", 32'(ff_out), 32'h08);
    @(negedge clk); lamp_test = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) ff_in[$urandom_range(0, 7)] ^= 1'b1;
      ack = ($urandom_range(0, 7) == 0);
      lamp_test = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk); reset = 1'b0; ack = 1'b0; lamp_test = 1'b0;

    // Narrow instance with a masked interlock.
    do_reset();
    @(negedge clk); ff_in3 = 3'b100;
    edges(9);
    chk("n3_ff", 32'(ff_out3), 32'h4);
    chk("n3_emerg", 32'(emergency3), 32'h1);
    chk("n3_ilk", 32'(interlock3), 32'h0);
    @(negedge clk); reset = 1'b1;
    edges(1);
    chk("n3_rst_ff", 32'(ff_out3), 32'h0);
    chk("n3_rst_la", 32'(ff_la3), 32'h0);
    chk("n3_rst_first", 32'(first_out3), 32'h0);
    chk("n3_rst_emerg", 32'(emergency3), 32'h0);
    edges(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
